// File: rtl/nmi_arbiter2_if.sv
// Native memory interface bundle: request from master to slave, ready/rdata back.
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_arbiter2.sv
// Two-master round-robin arbiter in front of one NMI slave, with a per-access
// bus timeout that completes the hung access with an error response.
module nmi_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    nmi_if.slave        m0,
    nmi_if.slave        m1,
    nmi_if.master       s,
    output logic        err_irq_o,
    output logic [31:0] err_addr_o,
    output logic        err_mst_o
);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TERR = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic              err_mst_q, err_mst_d;
    logic              pick;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        err_mst_d  = err_mst_q;
        // Contention resolves by the pointer, a lone requester always wins.
        pick       = (m0.valid && m1.valid) ? rr_q : m1.valid;

        case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    gnt_d   = pick;
                    addr_d  = pick ? m1.addr  : m0.addr;
                    wdata_d = pick ? m1.wdata : m0.wdata;
                    wstrb_d = pick ? m1.wstrb : m0.wstrb;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s.ready) begin
                    rr_d    = ~gnt_q;
                    state_d = IDLE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    // Error record is loaded on entry so it is valid alongside the irq pulse.
                    err_addr_d = addr_q;
                    err_mst_d  = gnt_q;
                    state_d    = TERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TERR: begin
                rr_d    = ~gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            err_addr_q <= '0;
            err_mst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            err_mst_q  <= err_mst_d;
        end
    end

    // Response path is combinational so the slave's ready reaches the master in the same cycle.
    always_comb begin
        rsp_ready = 1'b0;
        rsp_rdata = '0;
        if (state_q == BUSY) begin
            rsp_ready = s.ready;
            rsp_rdata = s.rdata;
        end else if (state_q == TERR) begin
            rsp_ready = 1'b1;
            rsp_rdata = ERR_RDATA;
        end
    end

    assign s.valid  = (state_q == BUSY);
    assign s.addr   = addr_q;
    assign s.wdata  = wdata_q;
    assign s.wstrb  = wstrb_q;

    assign m0.ready = rsp_ready & ~gnt_q;
    assign m0.rdata = gnt_q ? '0 : rsp_rdata;
    assign m1.ready = rsp_ready & gnt_q;
    assign m1.rdata = gnt_q ? rsp_rdata : '0;

    assign err_irq_o  = (state_q == TERR);
    assign err_addr_o = err_addr_q;
    assign err_mst_o  = err_mst_q;
endmodule

// File: doc/nmi_arbiter2.md
# nmi_arbiter2

Two-master, one-slave arbiter for the native memory interface (NMI). It shares the peripheral/memory NMI port between the CPU master and the DMA master (`dma_nmi`) ahead of the native-IP address decoder. It latches each granted request, holds it stable toward the slave until completion, alternates priority round-robin, and terminates hung accesses with a bus-timeout error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum slave-wait cycles per access; 0 disables the timeout.
- `ERR_RDATA`, default 32'hFFFF_FFFF: rdata returned on a timed-out access.

Ports:
- `clk_i`  input  1  system clock; single clock domain.
- `rst_n_i`  input  1  asynchronous active-low reset.
- `m0`  nmi_if.slave  —  CPU master port (valid, addr[31:0], wdata[31:0], wstrb[3:0] in; ready, rdata[31:0] out).
- `m1`  nmi_if.slave  —  DMA master port, same signals as `m0`.
- `s`  nmi_if.master  —  shared slave port toward the native-IP decoder.
- `err_irq_o`  output  1  one-cycle pulse on a bus timeout.
- `err_addr_o`  output  32  address of the last timed-out access.
- `err_mst_o`  output  1  master index of the last timed-out access.

## Operation
- FSM states: IDLE, BUSY, TERR.
- **IDLE:** evaluate `m0.valid` and `m1.valid`.
  - One requester: grant it.
  - Both requesting: grant the master selected by priority pointer `rr_q`. `rr_q`=0 favours m0; `rr_q`=1 favours m1.
  - On grant: latch addr, wdata and wstrb into `s`-side registers, store `gnt_q`, clear the timeout counter, go to BUSY.
- **BUSY:**
  - `s.valid`=1 with the latched request. The request is stable even if the master changes or drops its inputs.
  - `m[gnt].ready` = `s.ready` and `m[gnt].rdata` = `s.rdata`, both combinational. The non-granted master sees ready=0 and rdata=0.
  - When `s.ready`=1: go to IDLE, set `rr_q` = ~`gnt_q`.
- **Timeout:** the counter increments each BUSY cycle without `s.ready`.
  - When the counter reaches TIMEOUT_CYCLES-1 without `s.ready`, go to TERR.
  - If `s.ready` and the terminal count occur in the same cycle, `s.ready` wins and the access completes normally.
- **TERR (one cycle):**
  - `s.valid`=0.
  - `m[gnt].ready`=1 and `m[gnt].rdata`=ERR_RDATA. A timed-out write is dropped silently.
  - `err_irq_o`=1; `err_addr_o` is loaded with the latched addr and `err_mst_o` with `gnt_q`.
  - `rr_q` = ~`gnt_q`; go to IDLE.
- Master protocol: a master holds valid until it sees ready. A master that drops valid while granted still receives its ready pulse. It must ignore that pulse, and the arbiter does not check.
- Counter width: $clog2(TIMEOUT_CYCLES+1); saturating, never wraps.

## Timing
- Reset values:
  - State IDLE; `rr_q`=0; `gnt_q`=0; counter 0.
  - Outputs: `s.valid`/addr/wdata/wstrb = 0; `m0`/`m1` ready and rdata = 0; `err_irq_o`=0; `err_addr_o`=0; `err_mst_o`=0.
- Arbitration latency: a request seen in IDLE at cycle N drives `s.valid` at N+1.
- Slave ready at cycle K returns ready to the master in the same cycle K. Minimum access is 2 cycles for a zero-wait slave.
- One IDLE bubble follows every completion. A master that asserts a new valid at K+1 is arbitrated at K+1 and reaches the slave at K+2.
- Back-to-back contention alternates strictly: m0, m1, m0, …
- Timeout: with no `s.ready`, TERR occurs TIMEOUT_CYCLES cycles after BUSY entry. The `err_irq_o` pulse coincides with the error ready.
- `err_addr_o` and `err_mst_o` hold their value until the next timeout or reset.
- Reset asserted mid-access: immediate return to IDLE, all outputs to reset values, no ready issued. The master re-issues its request after reset.

## Test plan
- Single m0 read, slave ready 3 cycles after `s.valid`, rdata 32'h1234_5678 → `s.valid` rises 1 cycle after `m0.valid`; `m0.ready`=1 with rdata 32'h1234_5678; `m1.ready` stays 0.
- `m0` and `m1` both valid continuously from reset, zero-wait slave → grants m0, m1, m0, m1 with one idle cycle between each; addresses on `s` match the granted master.
- m1 write addr 32'h1000_A004 wstrb 4'hF; m1 changes its addr to 0 after grant; slave ready after 5 cycles → `s.addr` stays 32'h1000_A004 throughout; `m1.ready` is pulsed.
- TIMEOUT_CYCLES=16, slave never ready, m0 read of 32'h5000_0000 → after 16 BUSY cycles, `m0.ready`=1 with rdata 32'hFFFF_FFFF; `err_irq_o` pulses once; `err_addr_o`=32'h5000_0000; `err_mst_o`=0; next m1 request is served normally.
- TIMEOUT_CYCLES=16, `s.ready` arrives exactly on the 16th BUSY cycle → normal completion with slave rdata; no `err_irq_o`.
- `rst_n_i` pulsed low in the middle of a BUSY access → `s.valid` drops asynchronously; no master ready; after release, `rr_q`=0 and contention grants m0 first.
